// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP register-file write path.
// Entry layout for queued FP results plus a helper building scoreboard masks.
package fpu_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] wreg;
    logic [DATA_W-1:0]    data;
    logic [DATA_W-1:0]    data2;
    logic                 is_double;
  } wb_entry_t;

  // Bit for reg r, plus its odd partner when a double targets an even register.
  function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_IDX_W-1:0] r,
                                                  input logic dbl);
    logic [NUM_REGS-1:0] m;
    m = '0;
    m[r] = 1'b1;
    if (dbl && !r[0]) m[r + 1'b1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; head is read combinationally, no bypass.
// Storage is left unreset, only pointers and occupancy are cleared.
module wb_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        pushData,
  input  logic             pop,
  output wb_entry_t        popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// Merges integer results and queued FP results onto the register file's single
// registered write port, and tracks float registers with writes still in flight.
module fp_writeback_arbiter
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 int_valid,
  output logic                 int_ready,
  input  logic [REG_IDX_W-1:0] int_wreg,
  input  logic [DATA_W-1:0]    int_wdata,
  input  logic                 fp_valid,
  output logic                 fp_ready,
  input  logic [REG_IDX_W-1:0] fp_wreg,
  input  logic [DATA_W-1:0]    fp_wdata,
  input  logic [DATA_W-1:0]    fp_wdata2,
  input  logic                 fp_double,
  input  logic                 fp_issue_valid,
  input  logic [REG_IDX_W-1:0] fp_issue_reg,
  input  logic                 fp_issue_double,
  output logic                 regWSig,
  output logic                 regwrite_float,
  output logic [REG_IDX_W-1:0] wReg,
  output logic [DATA_W-1:0]    wData,
  output logic [DATA_W-1:0]    wData2,
  output logic                 double,
  output logic [NUM_REGS-1:0]  fp_busy_mask,
  output logic                 err_double_odd
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W    = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  logic [STARVE_W-1:0] starveCnt;
  wb_entry_t           pushEntry;
  wb_entry_t           headEntry;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [CNT_W-1:0]    fifoCount;
  logic                starveHit;
  logic                intGrant;
  logic                fpPush;
  logic                fpPop;
  logic                oddDouble;
  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;

  function automatic logic [STARVE_W-1:0] starveNext(input logic [STARVE_W-1:0] cur,
                                                     input logic grant,
                                                     input logic clr);
    if (clr) return '0;
    if (grant && cur != STARVE_W'(STARVE_LIMIT)) return cur + 1'b1;
    return cur;
  endfunction

  // Integer side yields one cycle once it has starved a non-empty FP queue.
  assign starveHit = (starveCnt == STARVE_W'(STARVE_LIMIT)) && !fifoEmpty;
  assign int_ready = !rst && !starveHit;
  assign fp_ready  = !rst && !fifoFull;
  assign intGrant  = int_valid && int_ready;
  assign fpPop     = !rst && !intGrant && !fifoEmpty;
  assign fpPush    = fp_valid && fp_ready;
  assign oddDouble = fp_double && fp_wreg[0];

  always_comb begin
    pushEntry.wreg      = fp_wreg;
    pushEntry.data      = fp_wdata;
    pushEntry.data2     = fp_wdata2;
    pushEntry.is_double = fp_double && !fp_wreg[0];
  end

  assign setMask = fp_issue_valid ? regMask(fp_issue_reg, fp_issue_double) : '0;
  assign clrMask = fpPop ? regMask(headEntry.wreg, headEntry.is_double) : '0;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fpPush),
    .pushData(pushEntry),
    .pop     (fpPop),
    .popData (headEntry),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  // Grant stage -> registered register-file write port
  always_ff @(posedge clk) begin
    if (rst) begin
      regWSig        <= 1'b0;
      regwrite_float <= 1'b0;
      wReg           <= '0;
      wData          <= '0;
      wData2         <= '0;
      double         <= 1'b0;
      starveCnt      <= '0;
      fp_busy_mask   <= '0;
      err_double_odd <= 1'b0;
    end else begin
      regWSig        <= intGrant;
      regwrite_float <= fpPop;
      if (intGrant) begin
        wReg   <= int_wreg;
        wData  <= int_wdata;
        wData2 <= '0;
        double <= 1'b0;
      end else if (fpPop) begin
        wReg   <= headEntry.wreg;
        wData  <= headEntry.data;
        wData2 <= headEntry.data2;
        double <= headEntry.is_double;
      end
      starveCnt <= starveNext(starveCnt, intGrant && !fifoEmpty,
                              fpPop || (fifoCount == '0));
      if (fpPush && oddDouble) err_double_odd <= 1'b1;
      // A new issue to a register being retired this cycle keeps it busy.
      fp_busy_mask <= (fp_busy_mask & ~clrMask) | setMask;
    end
  end

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed and randomized bench for fp_writeback_arbiter against a queue-based
// reference model of the write-back rules.
module tb_fp_writeback_arbiter;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid, int_ready;
  logic [4:0]  int_wreg;
  logic [31:0] int_wdata;
  logic        fp_valid, fp_ready;
  logic [4:0]  fp_wreg;
  logic [31:0] fp_wdata, fp_wdata2;
  logic        fp_double;
  logic        fp_issue_valid;
  logic [4:0]  fp_issue_reg;
  logic        fp_issue_double;
  logic        regWSig, regwrite_float;
  logic [4:0]  wReg;
  logic [31:0] wData, wData2;
  logic        double;
  logic [31:0] fp_busy_mask;
  logic        err_double_odd;

  always #5 clk = ~clk;

  fp_writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_ready(int_ready), .int_wreg(int_wreg), .int_wdata(int_wdata),
    .fp_valid(fp_valid), .fp_ready(fp_ready), .fp_wreg(fp_wreg), .fp_wdata(fp_wdata),
    .fp_wdata2(fp_wdata2), .fp_double(fp_double),
    .fp_issue_valid(fp_issue_valid), .fp_issue_reg(fp_issue_reg), .fp_issue_double(fp_issue_double),
    .regWSig(regWSig), .regwrite_float(regwrite_float), .wReg(wReg), .wData(wData),
    .wData2(wData2), .double(double), .fp_busy_mask(fp_busy_mask), .err_double_odd(err_double_odd)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  wb_entry_t   mq[$];
  int          mStarve = 0;
  logic [31:0] mMask = '0;
  logic        mErr = 1'b0;
  logic        eW = 1'b0, eF = 1'b0, eDbl = 1'b0;
  logic [4:0]  eReg = '0;
  logic [31:0] eData = '0, eData2 = '0;
  bit          chkData = 1'b0, chkData2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bitsFor(input int r, input bit dbl);
    logic [31:0] m;
    m = '0;
    m[r] = 1'b1;
    if (dbl && (r % 2 == 0)) m[(r + 1) % 32] = 1'b1;
    return m;
  endfunction

  task automatic idle();
    rst = 1'b0; int_valid = 1'b0; int_wreg = '0; int_wdata = '0;
    fp_valid = 1'b0; fp_wreg = '0; fp_wdata = '0; fp_wdata2 = '0; fp_double = 1'b0;
    fp_issue_valid = 1'b0; fp_issue_reg = '0; fp_issue_double = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; checks, advances the
  // model across the next rising edge, and returns at the following falling edge.
  task automatic step(input bit doChk);
    bit        intRdy, fpRdy, intG, popG, emptyNow;
    wb_entry_t e;
    #1;
    emptyNow = (mq.size() == 0);
    intRdy   = !rst && !(mStarve == LIMIT && !emptyNow);
    fpRdy    = !rst && (mq.size() < DEPTH);
    if (doChk) begin
      chk("int_ready", int_ready, intRdy);
      chk("fp_ready", fp_ready, fpRdy);
      chk("regWSig", regWSig, eW);
      chk("regwrite_float", regwrite_float, eF);
      chk("fp_busy_mask", fp_busy_mask, mMask);
      chk("err_double_odd", err_double_odd, mErr);
      if (chkData) begin
        chk("wReg", wReg, eReg);
        chk("wData", wData, eData);
        chk("double", double, eDbl);
        if (chkData2) chk("wData2", wData2, eData2);
      end
    end
    if (rst) begin
      mq.delete(); mStarve = 0; mMask = '0; mErr = 1'b0;
      eW = 1'b0; eF = 1'b0; eReg = '0; eData = '0; eData2 = '0; eDbl = 1'b0;
      chkData = 1'b1; chkData2 = 1'b1;
    end else begin
      intG = int_valid && intRdy;
      popG = !intG && !emptyNow;
      eW = intG; eF = popG; chkData = intG || popG; chkData2 = popG;
      if (intG) begin
        eReg = int_wreg; eData = int_wdata; eDbl = 1'b0;
      end else if (popG) begin
        e = mq.pop_front();
        eReg = e.wreg; eData = e.data; eData2 = e.data2; eDbl = e.is_double;
        mMask = mMask & ~bitsFor(int'(e.wreg), e.is_double);
      end
      if (popG || emptyNow) mStarve = 0;
      else if (intG && mStarve < LIMIT) mStarve++;
      if (fp_valid && fpRdy) begin
        if (fp_double && fp_wreg[0]) mErr = 1'b1;
        e.wreg = fp_wreg; e.data = fp_wdata; e.data2 = fp_wdata2;
        e.is_double = fp_double && !fp_wreg[0];
        mq.push_back(e);
      end
      if (fp_issue_valid) mMask = mMask | bitsFor(int'(fp_issue_reg), fp_issue_double);
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;
    step(1'b1);

    // Single integer write
    int_valid = 1'b1; int_wreg = 5'd5; int_wdata = 32'hDEADBEEF;
    step(1'b1);
    idle();
    step(1'b1);
    step(1'b1);

    // Double issue on reg 4, later FP push and write-back
    fp_issue_valid = 1'b1; fp_issue_reg = 5'd4; fp_issue_double = 1'b1;
    step(1'b1);
    idle();
    step(1'b1);
    fp_valid = 1'b1; fp_wreg = 5'd4; fp_wdata = 32'h3F800000; fp_wdata2 = '0; fp_double = 1'b1;
    step(1'b1);
    idle();
    for (int i = 0; i < 4; i++) step(1'b1);

    // One queued FP entry against a continuous integer stream
    int_valid = 1'b1; int_wreg = 5'd1; int_wdata = $urandom;
    fp_valid = 1'b1; fp_wreg = 5'd10; fp_wdata = 32'h11111111;
    step(1'b1);
    fp_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int_wreg = 5'(i); int_wdata = $urandom;
      step(1'b1);
    end
    idle();
    step(1'b1);

    // Fill the queue while integer traffic is continuous, then drain
    int_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fp_valid = 1'b1; fp_wreg = 5'(16 + i); fp_wdata = 32'hA0 + 32'(i); fp_wdata2 = 32'hB0 + 32'(i);
      int_wreg = 5'(i); int_wdata = $urandom;
      step(1'b1);
    end
    idle();
    for (int i = 0; i < 6; i++) step(1'b1);

    // Double to an odd register
    fp_valid = 1'b1; fp_wreg = 5'd7; fp_double = 1'b1; fp_wdata = 32'h12345678; fp_wdata2 = 32'h9ABCDEF0;
    step(1'b1);
    idle();
    for (int i = 0; i < 4; i++) step(1'b1);

    // Reset with queued entries and busy bits
    fp_issue_valid = 1'b1; fp_issue_reg = 5'd4; fp_issue_double = 1'b1;
    int_valid = 1'b1; int_wdata = 32'h55;
    fp_valid = 1'b1; fp_wreg = 5'd20; fp_wdata = 32'h1;
    step(1'b1);
    fp_issue_valid = 1'b0; fp_wreg = 5'd22; fp_wdata = 32'h2;
    step(1'b1);
    fp_wreg = 5'd24; fp_wdata = 32'h3;
    step(1'b1);
    idle();
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 63) == 0);
      int_valid       = ($urandom_range(0, 2) != 0);
      int_wreg        = 5'($urandom_range(0, 31));
      int_wdata       = $urandom;
      fp_valid        = ($urandom_range(0, 1) == 1);
      fp_wreg         = 5'($urandom_range(0, 31));
      fp_wdata        = $urandom;
      fp_wdata2       = $urandom;
      fp_double       = ($urandom_range(0, 1) == 1);
      fp_issue_valid  = ($urandom_range(0, 3) == 0);
      fp_issue_reg    = 5'($urandom_range(0, 31));
      fp_issue_double = ($urandom_range(0, 1) == 1);
      step(1'b1);
    end
    idle();
    for (int i = 0; i < 8; i++) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_writeback_arbiter.md
Name: fp_writeback_arbiter

Overview:
- Write-side companion of the dual-bank (integer/float) register file. Merges integer pipeline results and multi-cycle FP unit results onto the file's single registered write port.
- Supports double-precision pair writes to wReg/wReg+1.
- Keeps a pending-write scoreboard of float registers for the decode-stage hazard logic.
- Sits between the EX/MEM result buses and the register file write inputs.

Parameters:
- FIFO_DEPTH, 4, FP result queue entries (power of 2, ≥2)
- STARVE_LIMIT, 3, consecutive integer grants with FP queue non-empty before integer side is stalled one cycle

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- int_valid  in  1  integer result present
- int_ready  out  1  integer result accepted this cycle
- int_wreg  in  5  integer destination
- int_wdata  in  32  integer result
- fp_valid  in  1  FP result present
- fp_ready  out  1  FP queue can accept
- fp_wreg  in  5  float destination
- fp_wdata  in  32  FP result (low/single)
- fp_wdata2  in  32  second word for double
- fp_double  in  1  pair write
- fp_issue_valid  in  1  FP op issued (scoreboard set)
- fp_issue_reg  in  5  issued destination
- fp_issue_double  in  1  issued op is double
- regWSig  out  1  integer bank write enable
- regwrite_float  out  1  float bank write enable
- wReg  out  5  write register
- wData  out  32  write data
- wData2  out  32  second word
- double  out  1  pair write
- fp_busy_mask  out  32  bit i=1: float reg i has outstanding write
- err_double_odd  out  1  sticky: double with odd destination seen

Behaviour:
- Reset: synchronous, active-high. All register-file outputs 0, FIFO empty, fp_busy_mask 0, err_double_odd 0, starve counter 0. int_ready and fp_ready are 0 while rst=1.
- Register-file outputs are registered. A grant decided in cycle N appears on the outputs in cycle N+1 for exactly one cycle; otherwise both enables are 0. regWSig and regwrite_float are never both 1.
- fp_ready = !full, computed from the current count. A pop in the same cycle does not free a slot.
- Push happens when fp_valid && fp_ready. There is no bypass: a pushed entry is poppable from N+1 at the earliest, so it is written to the file at N+2 at the earliest.
- Grant rule each cycle:
  - If int_valid && int_ready: integer write. Outputs regWSig=1, wReg=int_wreg, wData=int_wdata, double=0.
  - Else if FIFO non-empty: pop the head. Outputs regwrite_float=1, wReg, wData, wData2, double.
- int_ready = !rst && !(starve_cnt==STARVE_LIMIT && fifo non-empty).
- starve_cnt:
  - Increments on an integer grant while the FIFO is non-empty, saturating at STARVE_LIMIT.
  - Clears on any FP pop or when the FIFO is empty.
- Double check at push: if fp_double && fp_wreg[0]==1, err_double_odd is set (sticky until rst) and the entry is stored with double=0 (single write).
- Scoreboard:
  - Set: on fp_issue_valid, bit issue_reg is set, plus bit issue_reg+1 if issue_double and issue_reg is even.
  - Clear: on the edge that registers an FP write, the same bit(s) are cleared.
  - A set and a clear of the same bit in the same cycle: set wins.
  - Index wrap is mod 32, but is never reached because of the even-register rule.
- Integer writes to register 0 pass through unchanged. The file decides semantics.
- rst mid-operation discards queued entries and clears the mask. No write is emitted in the cycle after rst.

Decomposition:
- Shared package fpu_pkg:
  - typedef wb_entry_t {wreg[4:0], data[31:0], data2[31:0], is_double}
  - constants NUM_REGS=32 and REG_IDX_W=5
- One sub-module: wb_fifo. Parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count.
- Arbitration, starve counter and scoreboard live in the top level.

Test Plan:
- int_valid=1, int_wreg=5, int_wdata=0xDEADBEEF at cycle 1 → cycle 2: regWSig=1, wReg=5, wData=0xDEADBEEF; cycle 3 enables 0.
- fp_issue_valid reg=4 double at cycle 1, then fp push at cycle 3 (wreg=4, data=0x3F800000, data2=0x0, double) → mask bits 4,5 set from cycle 2; regwrite_float=1 with double=1 at cycle 5; bits clear at cycle 5.
- One FP entry queued, int_valid held 1 continuously → int granted 3 times, int_ready=0 for one cycle, FP written next, then int resumes.
- Push 4 FP entries with int_valid held 1 and STARVE_LIMIT large → fp_ready=0 after the 4th; a 5th fp_valid is held off; entries drain in order 0..3 once int idles.
- fp push wreg=7, double=1 → err_double_odd=1, write emitted with double=0, wReg=7; error stays 1 until rst.
- rst asserted with 3 entries queued and mask=0x30 → next cycle: all outputs 0, mask 0, fp_ready=1 after rst deasserts, no stale writes.
